// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Per-button 2-flop synchronizer, debounce FSM and one-cycle
//            press / release / long-press event strobes.
//            Optional long-press detection: BUTTON_CONDITIONER_LONG_PRESS_EN
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int N_BUTTONS         = 4,
  parameter int ACTIVE_LOW        = 1,
  parameter int DEBOUNCE_CYCLES   = 500_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic                 sys_clk_50m,
  input  logic                 sys_rst_n,
  input  logic [N_BUTTONS-1:0] buttons_in,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_DEB = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // Raw level that means "released", loaded into the synchronizer on reset
  localparam logic [N_BUTTONS-1:0] C_SYNC_RST = {N_BUTTONS{(ACTIVE_LOW != 0)}};

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Elaboration-time sanity checks on the timing parameters
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long_press
    $error("LONG_PRESS_CYCLES must be >= 1");
  end

  logic [N_BUTTONS-1:0] sync1_q, sync1_d;
  logic [N_BUTTONS-1:0] sync2_q, sync2_d;
  logic [N_BUTTONS-1:0] sync_pressed;

  // Synchronizer next values and polarity normalisation (1 = pressed)
  always_comb begin
    sync1_d      = buttons_in;
    sync2_d      = sync1_q;
    sync_pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  end

  // Two-flop synchronizer register
  always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= C_SYNC_RST;
      sync2_q <= C_SYNC_RST;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;

    // State register: FSM state, debounce counter and registered outputs
    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_q         <= ST_RELEASED;
        cnt_q           <= '0;
        pressed_q       <= 1'b0;
        press_pulse_q   <= 1'b0;
        release_pulse_q <= 1'b0;
      end else begin
        state_q         <= state_d;
        cnt_q           <= cnt_d;
        pressed_q       <= pressed_d;
        press_pulse_q   <= press_pulse_d;
        release_pulse_q <= release_pulse_d;
      end
    end

    // Next-state logic: a new level must hold for DEBOUNCE_CYCLES samples
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_RELEASED: begin
          if (sync_pressed[i]) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = C_CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync_pressed[i]) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == C_DEB) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!sync_pressed[i]) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = C_CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync_pressed[i]) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == C_DEB) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    // Output logic: level follows the accepted state, strobes mark acceptance
    always_comb begin
      pressed_d       = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
      press_pulse_d   = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);
      release_pulse_d = (state_q == ST_RELEASE_WAIT) && (state_d == ST_RELEASED);
    end

    assign pressed[i]       = pressed_q;
    assign press_pulse[i]   = press_pulse_q;
    assign release_pulse[i] = release_pulse_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] C_LONG = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_pulse_q, long_pulse_d;

    // Hold timer: runs while held, saturates at the threshold so the strobe
    // fires once; a rejected release bounce keeps the accumulated hold time
    always_comb begin
      hold_d       = hold_q;
      long_pulse_d = 1'b0;
      if ((state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED)) begin
        hold_d = '0;
      end else if (state_d == ST_RELEASED) begin
        hold_d = '0;
      end else if (((state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT)) &&
                   (hold_q != C_LONG)) begin
        hold_d       = hold_q + C_HOLD_ONE;
        long_pulse_d = (hold_d == C_LONG);
      end
    end

    // Hold timer and long-press strobe register
    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        hold_q       <= '0;
        long_pulse_q <= 1'b0;
      end else begin
        hold_q       <= hold_d;
        long_pulse_q <= long_pulse_d;
      end
    end

    assign long_press_pulse[i] = long_pulse_q;
`else
    assign long_press_pulse[i] = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Directed self-checking bench for button_conditioner
//            (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, ACTIVE_LOW=1).
//            Long-press checks follow BUTTON_CONDITIONER_LONG_PRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int N   = 4;
  localparam int DEB = 8;
  localparam int LNG = 32;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] buttons_in;
  logic [N-1:0] pressed;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press_pulse;

  int n_checks;
  int n_errors;

  int press_cnt   [N];
  int release_cnt [N];
  int long_cnt    [N];

  button_conditioner #(
    .N_BUTTONS        (N),
    .ACTIVE_LOW       (1),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LNG)
  ) dut (
    .sys_clk_50m     (clk),
    .sys_rst_n       (rst_n),
    .buttons_in      (buttons_in),
    .pressed         (pressed),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running tally of strobes per channel, sampled away from the active edge
  initial begin
    for (int i = 0; i < N; i++) begin
      press_cnt[i]   = 0;
      release_cnt[i] = 0;
      long_cnt[i]    = 0;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (press_pulse[i])      press_cnt[i]   = press_cnt[i] + 1;
      if (release_pulse[i])    release_cnt[i] = release_cnt[i] + 1;
      if (long_press_pulse[i]) long_cnt[i]    = long_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int snap;
  int all_cnt;
  logic [N-1:0] any_out;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    buttons_in = 4'hF;

    // 1. reset with all buttons released, then 100 idle cycles
    cycles(3);
    check("rst_pressed", 32'(pressed), 32'h0);
    check("rst_pulses", 32'(press_pulse | release_pulse | long_press_pulse), 32'h0);
    rst_n = 1'b1;
    any_out = '0;
    for (int c = 0; c < 100; c++) begin
      cycles(1);
      any_out = any_out | pressed | press_pulse | release_pulse | long_press_pulse;
    end
    check("idle_outputs", 32'(any_out), 32'h0);

    // 2. clean press of bit 0: edges T..T+10
    buttons_in = 4'hE;
    cycles(10);
    check("b0_before", 32'({pressed, press_pulse}), 32'h00);
    cycles(1);
    check("b0_press_level", 32'(pressed), 32'h1);
    check("b0_press_pulse", 32'(press_pulse), 32'h1);
    cycles(1);
    check("b0_pulse_one_cycle", 32'({pressed, press_pulse}), 32'h10);

    // 3. bouncy press of bit 1, steady from edge U
    snap = press_cnt[1];
    buttons_in = 4'hC;
    cycles(5);
    buttons_in = 4'hE;
    cycles(1);
    buttons_in = 4'hC;
    cycles(10);
    check("b1_no_early_pulse", 32'(press_cnt[1] - snap), 32'd0);
    cycles(1);
    check("b1_press_pulse", 32'(press_pulse), 32'h2);
    check("b1_press_level", 32'(pressed), 32'h3);

    // 4. press then release bit 2 (release edge V), then bits 2+3 together
    buttons_in = 4'h8;
    cycles(12);
    check("b2_held", 32'(pressed), 32'h7);
    buttons_in = 4'hC;
    cycles(10);
    check("b2_before_release", 32'({pressed, release_pulse}), 32'h70);
    cycles(1);
    check("b2_release_pulse", 32'(release_pulse), 32'h4);
    check("b2_release_level", 32'(pressed), 32'h3);
    buttons_in = 4'h0;
    cycles(11);
    check("b23_simul_press", 32'(press_pulse), 32'hC);
    check("b23_level", 32'(pressed), 32'hF);

    // 5. long press on bits 2/3 measured from their press strobe
    snap = long_cnt[3];
    cycles(LNG - 1);
    check("long_before", 32'(long_press_pulse), 32'h0);
    cycles(1);
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    check("long_pulse", 32'(long_press_pulse), 32'hC);
    cycles(1);
    check("long_one_cycle", 32'(long_press_pulse), 32'h0);
    cycles(40);
    check("long_once", 32'(long_cnt[3] - snap), 32'd1);
`else
    check("long_disabled", 32'(long_press_pulse), 32'h0);
    cycles(41);
    all_cnt = 0;
    for (int i = 0; i < N; i++) all_cnt += long_cnt[i];
    check("long_never", 32'(all_cnt), 32'd0);
`endif

    // 6. reset mid-debounce of bit 0 while bit 3 is held
    buttons_in = 4'h7;
    cycles(20);
    check("pre_rst_level", 32'(pressed), 32'h8);
    buttons_in = 4'h6;
    cycles(6);
    rst_n = 1'b0;
    #1;
    check("rst_async_level", 32'(pressed), 32'h0);
    check("rst_async_pulses", 32'(press_pulse | release_pulse | long_press_pulse), 32'h0);
    cycles(3);
    snap = press_cnt[0];
    rst_n = 1'b1;
    cycles(10);
    check("post_rst_no_early", 32'({pressed, press_pulse}), 32'h00);
    check("post_rst_cnt", 32'(press_cnt[0] - snap), 32'd0);
    cycles(1);
    check("post_rst_press_pulse", 32'(press_pulse), 32'h9);
    check("post_rst_level", 32'(pressed), 32'h9);
    cycles(1);
    check("post_rst_pulse_end", 32'(press_pulse), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side counterpart to the LED drive path: takes raw, bouncy push-button pins and turns them into clean, synchronous button state and event pulses.
- Per button: 2-flop synchronizer, then a debounce FSM with a counter, then one-cycle press/release pulses and an optional long-press pulse.
- Sits between the board button pins and fabric logic or Nios PIO inputs, which then see glitch-free levels and edges.

Parameters:
- N_BUTTONS, 4: number of independent button channels.
- ACTIVE_LOW, 1: 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 500_000: consecutive stable cycles needed to accept a new level (10 ms at 50 MHz). Must be >= 1.
- LONG_PRESS_CYCLES, 50_000_000: cycles held after debounced press before the long-press event (1 s at 50 MHz). Must be >= 1.

Ports:
- sys_clk_50m  in  1  system clock; the only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- buttons_in  in  N_BUTTONS  raw, asynchronous button pins.
- pressed  out  N_BUTTONS  debounced level, active-high (1 = pressed).
- press_pulse  out  N_BUTTONS  one-cycle strobe on accepted press.
- release_pulse  out  N_BUTTONS  one-cycle strobe on accepted release.
- long_press_pulse  out  N_BUTTONS  one-cycle strobe on long press.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset:
  - All outputs go to 0.
  - Synchronizer flops load the "released" raw value: 1 if ACTIVE_LOW, else 0.
  - All counters clear to 0 and every FSM goes to RELEASED.
- Synchronizer: 2 flops per bit. Polarity is normalized after the second flop to s = 1 meaning pressed.
- FSM per channel, 4 states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: if s = 1, go to PRESS_WAIT with cnt = 1.
  - PRESS_WAIT:
    - If s = 0, return to RELEASED with cnt = 0 (bounce rejected, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES, go to PRESSED, set pressed = 1 and pulse press_pulse.
    - Else cnt++.
  - PRESSED: if s = 0, go to RELEASE_WAIT with cnt = 1.
  - RELEASE_WAIT: mirror of PRESS_WAIT. On success go to RELEASED, set pressed = 0 and pulse release_pulse. On bounce return to PRESSED silently.
- Timing:
  - pressed and press_pulse change in the same cycle.
  - The pulse is high for exactly 1 cycle.
  - Latency from the first clock edge sampling a new stable raw level to the output change is DEBOUNCE_CYCLES + 2 cycles.
- Counter width: $clog2(DEBOUNCE_CYCLES + 1). The counter never wraps; it stops at DEBOUNCE_CYCLES because the state changes.
- With DEBOUNCE_CYCLES = 1, one stable synchronized sample is enough (latency 3).
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Input toggling every cycle forever: no output change, no pulse.
- Reset asserted mid-debounce or mid-hold aborts immediately. No pulse is emitted on reset entry or exit.
  - A button held through reset release is re-debounced from zero and produces a press_pulse.

Optional Feature:
- Macro: BUTTON_CONDITIONER_LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter of width $clog2(LONG_PRESS_CYCLES + 1), cleared on entering PRESSED.
  - It increments each cycle while in PRESSED or RELEASE_WAIT.
  - When it reaches LONG_PRESS_CYCLES, long_press_pulse fires for one cycle, then the counter saturates with no repeat.
  - It clears on entering RELEASED.
  - A rejected release bounce does not clear it.
- Not defined: long_press_pulse is tied to 0 and no hold counter is instantiated.

Test Plan (DEBOUNCE_CYCLES = 8, LONG_PRESS_CYCLES = 32, ACTIVE_LOW = 1, N_BUTTONS = 4):
1. Hold reset with buttons_in = 4'hF, then release. Expected: all outputs 0 throughout, and no pulses for 100 cycles.
2. buttons_in[0] drops to 0 at edge T and stays there. Expected: pressed[0] = 1 and press_pulse[0] = 1 at T+10 only; no other bits move.
3. buttons_in[1] goes 0 for 5 cycles, 1 for 1 cycle, then 0 steady from edge U. Expected: no pulse before U+10; a single press_pulse[1] at U+10.
4. Hold bit 2 pressed, then return it to 1 at edge V. Expected: release_pulse[2] at V+10, pressed[2] falls in the same cycle; bits 2 and 3 pressed together pulse in the same cycle.
5. Macro defined, bit 3 held. Expected: long_press_pulse[3] exactly 32 cycles after press_pulse[3], once only; with the macro undefined it stays 0.
6. Assert sys_rst_n = 0 for 3 cycles while cnt = 4 with bit 0 held low. Expected: outputs 0 immediately; after release, press_pulse[0] at 10 cycles after the first sampling edge.
